// File: rtl/phys_free_list.sv
// phys_free_list
// Circular free list of physical register indices for the rename stage.
// The list holds one entry per physical register and has three pointers:
//   head        - speculative read pointer; rename allocates from here
//   commit_head - read pointer of retired allocations; flush restores head to it
//   tail        - write pointer; retiring instructions return old mappings here
// Pointers carry an extra wrap bit, so the list is empty when head == tail.
//
// Ports:
//   CLK, RESET          clock, asynchronous active-high reset
//   Alloc_IN            rename requests one destination register
//   AllocReg_OUT        register at head (valid when AllocValid_OUT)
//   AllocValid_OUT      list non-empty
//   Retire_IN           oldest allocating instruction retires
//   RetireOldReg_IN     its superseded mapping, returned to the list
//   Flush_IN            squash every non-retired allocation
//   BusyReg_OUT         register-file busy port: index
//   SetBusy_OUT         register-file busy port: write enable
//   BusyValue_OUT       register-file busy port: value (always 1)
//   FreeCount_OUT       tail - head
//   dbg_head, dbg_commit_head, dbg_tail  raw pointer state for observation
//
// Handshake: an allocation happens on a rising edge where Alloc_IN=1,
// AllocValid_OUT=1 and Flush_IN=0; rename stalls while AllocValid_OUT=0.
// Retire has no back-pressure: it is always accepted on the edge it is seen.
module phys_free_list #(
    parameter int NUM_PHYS_REGS = 64,
    parameter int NUM_ARCH_REGS = 32,
    localparam int LOG_PHYS = $clog2(NUM_PHYS_REGS),
    localparam int PTR_W    = LOG_PHYS + 1
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                Alloc_IN,
    output logic [LOG_PHYS-1:0] AllocReg_OUT,
    output logic                AllocValid_OUT,
    input  logic                Retire_IN,
    input  logic [LOG_PHYS-1:0] RetireOldReg_IN,
    input  logic                Flush_IN,
    output logic [LOG_PHYS-1:0] BusyReg_OUT,
    output logic                SetBusy_OUT,
    output logic                BusyValue_OUT,
    output logic [PTR_W-1:0]    FreeCount_OUT,
    output logic [PTR_W-1:0]    dbg_head,
    output logic [PTR_W-1:0]    dbg_commit_head,
    output logic [PTR_W-1:0]    dbg_tail
);

    localparam int NUM_FREE_AT_RESET = NUM_PHYS_REGS - NUM_ARCH_REGS;

    logic [LOG_PHYS-1:0] entries [NUM_PHYS_REGS];
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    commit_head;
    logic [PTR_W-1:0]    tail;

    logic                alloc_fire;
    logic [PTR_W-1:0]    commit_head_next;

    // All read-side outputs depend on registered state only.
    assign AllocValid_OUT = (head != tail);
    assign AllocReg_OUT   = entries[head[LOG_PHYS-1:0]];
    assign FreeCount_OUT  = tail - head;

    assign alloc_fire     = Alloc_IN & AllocValid_OUT & ~Flush_IN;

    // The register file writes the busy bit on the same edge the allocation
    // advances head, so the enable is the allocate-fire itself.
    assign SetBusy_OUT    = alloc_fire;
    assign BusyReg_OUT    = AllocReg_OUT;
    assign BusyValue_OUT  = 1'b1;

    // Retire is older than a same-cycle flush, so flush restores head to the
    // post-retire commit pointer.
    assign commit_head_next = Retire_IN ? commit_head + PTR_W'(1) : commit_head;

    assign dbg_head        = head;
    assign dbg_commit_head = commit_head;
    assign dbg_tail        = tail;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            head        <= '0;
            commit_head <= '0;
            tail        <= PTR_W'(NUM_FREE_AT_RESET);
        end else begin
            commit_head <= commit_head_next;
            if (Retire_IN) begin
                tail <= tail + PTR_W'(1);
            end
            if (Flush_IN) begin
                head <= commit_head_next;
            end else if (alloc_fire) begin
                head <= head + PTR_W'(1);
            end
        end
    end

    // Registers NUM_ARCH_REGS and up start free; the low ones hold the
    // architectural mappings and are not in the list at reset.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NUM_PHYS_REGS; i++) begin
                entries[i] <= (i < NUM_FREE_AT_RESET) ? LOG_PHYS'(NUM_ARCH_REGS + i) : '0;
            end
        end else if (Retire_IN) begin
            entries[tail[LOG_PHYS-1:0]] <= RetireOldReg_IN;
        end
    end

endmodule
